scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter IN_W, default 4, address width (decoder is IN_W-to-2^IN_W).
REQ-002 SHALL have parameter DWELL_W, default 8, width of the scan dwell count.
REQ-003 SHALL derive localparam OUT_W = 2**IN_W, not overridable.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  1  block enable; 0 forces outputs to zero.
REQ-007 SHALL have port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 SHALL have port in_valid  input  1  address offered (direct mode).
REQ-009 SHALL have port in_ready  output  1  address accepted when in_valid and in_ready are both 1.
REQ-010 SHALL have port addr  input  IN_W  address to decode.
REQ-011 SHALL have port dwell  input  DWELL_W  scan hold length; each output is held for dwell+1 cycles.
REQ-012 SHALL have port out_onehot  output  OUT_W  registered one-hot decode, or all-zero.
REQ-013 SHALL have port out_valid  output  1  out_onehot is non-zero.
REQ-014 SHALL have port cur_addr  output  IN_W  index currently driven.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when scan advances from OUT_W-1 to 0.

Function
REQ-016 SHALL implement FSM states IDLE, DIRECT, SCAN, all evaluated per clock.
REQ-017 SHALL go to IDLE from any state when en=0; else to DIRECT when mode=0 and to SCAN when mode=1.
REQ-018 In IDLE, out_onehot SHALL be 0, out_valid 0, in_ready 0, wrap 0, and cur_addr 0.
REQ-019 In DIRECT, in_ready SHALL be 1; on handshake, out_onehot SHALL become 1<<addr, cur_addr = addr, out_valid = 1 on the next edge (latency 1).
REQ-020 In DIRECT without a handshake, outputs SHALL hold their last value.
REQ-021 On entry to DIRECT from IDLE or SCAN, outputs SHALL be zero and out_valid 0 until the first handshake.
REQ-022 In SCAN, in_ready SHALL be 0 and in_valid/addr SHALL be ignored.
REQ-023 On entry to SCAN, dwell SHALL be latched and cur_addr SHALL be 0, with out_onehot = 1 on the first SCAN cycle.
REQ-024 In SCAN, each index SHALL be held for latched dwell+1 cycles, then cur_addr SHALL increment by 1 modulo OUT_W.
REQ-025 The latched dwell SHALL reload on every index advance, so dwell changes take effect at the next advance.
REQ-026 dwell = 0 SHALL advance every cycle.
REQ-027 wrap SHALL be 1 for exactly the cycle in which cur_addr = 0 following cur_addr = OUT_W-1, and 0 otherwise.
REQ-028 out_onehot SHALL always equal 1<<cur_addr whenever out_valid=1, and SHALL never have more than one bit set.
REQ-029 A mode change SHALL take effect on the next edge; direct-to-scan SHALL restart at index 0 and scan-to-direct SHALL clear outputs.
REQ-030 en=0 SHALL override mode and handshake in the same cycle, with outputs zero on the next edge.

Reset
REQ-031 When rst_n=0 at a clock edge, the FSM SHALL enter IDLE and all outputs and counters SHALL be zero on that edge.
REQ-032 Reset asserted mid-scan or mid-handshake SHALL discard the in-flight state; after release, operation SHALL restart per REQ-017.
REQ-033 rst_n SHALL have priority over en, mode and in_valid.

Structure
REQ-034 Package scan_decoder_pkg SHALL hold the state typedef (IDLE, DIRECT, SCAN) and the mode constants MODE_DIRECT=0 and MODE_SCAN=1.
REQ-035 The dwell countdown SHALL be a sub-module scan_dwell_timer, with load, tick and expire signals, parametrised by DWELL_W.
REQ-036 The decode itself SHALL be a single registered shift of cur_addr, with no latches and no combinational path from addr to out_onehot.

Verification
REQ-037 Case 1: reset, then en=1, mode=0, in_valid=1, addr=5 -> next cycle out_onehot=0x0020, out_valid=1, in_ready=1.
REQ-038 Case 2: IN_W=4, mode=1, dwell=2 -> cur_addr 0,0,0,1,1,1,...; wrap high one cycle at 15->0, first at cycle 48.
REQ-039 Case 3: mode=1, dwell=0 -> cur_addr increments every cycle, wrap every 16 cycles, in_ready=0 with in_valid=1 ignored.
REQ-040 Case 4: scan at cur_addr=7, drop en -> next cycle out_onehot=0, out_valid=0; raise en -> restart at index 0.
REQ-041 Case 5: rst_n=0 for 1 cycle mid-scan at cur_addr=9 -> all outputs 0 on that edge, then scan resumes from 0.
REQ-042 Case 6: sweep addr 0..15 in direct mode with IN_W=4, then re-run with IN_W=3 -> one-hot matches 1<<addr for every value, checked by a scoreboard.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// ============================================================================
// scan_decoder_pkg : state encoding and mode constants for scan_decoder
// Revision 1.0
// ============================================================================
`default_nettype none

package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/scan_dwell_timer.sv
// ============================================================================
// scan_dwell_timer : down-counter that sets how long each scan index is held
// Revision 1.0
// ============================================================================
`default_nettype none

module scan_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic               tick,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  // load wins over tick so an advance can reload in the same cycle it expires
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

`default_nettype wire

// File: rtl/scan_decoder.sv
// ============================================================================
// scan_decoder : registered IN_W-to-2^IN_W decoder with direct and auto-scan modes
// Revision 1.0
// ============================================================================
`default_nettype none

module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter  int IN_W    = 4,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2**IN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out_onehot,
  output logic               out_valid,
  output logic [IN_W-1:0]    cur_addr,
  output logic               wrap
);

  state_t            state;
  state_t            state_nx;
  logic [IN_W-1:0]   cur_nx;
  logic              valid_nx;
  logic              wrap_nx;
  logic              tmr_load;
  logic              tmr_tick;
  logic              tmr_clr;
  logic              tmr_expire;

  assign in_ready = rst_n && en && (mode == MODE_DIRECT) && (state == DIRECT);
  assign tmr_clr  = (state_nx != SCAN);

  scan_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .tick     (tmr_tick),
    .load_val (dwell),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_nx = IDLE;
    cur_nx   = '0;
    valid_nx = 1'b0;
    wrap_nx  = 1'b0;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT) begin
        state_nx = DIRECT;
        // entering DIRECT leaves outputs cleared until the first handshake
        if (state == DIRECT) begin
          cur_nx   = cur_addr;
          valid_nx = out_valid;
          if (in_valid && in_ready) begin
            cur_nx   = addr;
            valid_nx = 1'b1;
          end
        end
      end else begin
        state_nx = SCAN;
        valid_nx = 1'b1;
        if (state != SCAN) begin
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          tmr_load = 1'b1;
          cur_nx   = cur_addr + 1'b1;
          wrap_nx  = &cur_addr;
        end else begin
          tmr_tick = 1'b1;
          cur_nx   = cur_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      out_valid  <= 1'b0;
      wrap       <= 1'b0;
      out_onehot <= '0;
    end else begin
      state      <= state_nx;
      cur_addr   <= cur_nx;
      out_valid  <= valid_nx;
      wrap       <= wrap_nx;
      out_onehot <= valid_nx ? (OUT_W'(1) << cur_nx) : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_decoder.sv
// ============================================================================
// tb_scan_decoder : directed + random bench with a cycle-level reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  addr4 = '0;
  logic [2:0]  addr3 = '0;
  logic [7:0]  dwell = '0;

  logic        rdy4, ov4, wrap4;
  logic [15:0] oh4;
  logic [3:0]  cur4;
  logic        rdy3, ov3, wrap3;
  logic [7:0]  oh3;
  logic [2:0]  cur3;

  int checks = 0;
  int failures = 0;

  int m_st = 0;
  int m_addr = 0;
  int m_age = 0;
  int m_dw = 0;
  bit m_valid = 0;
  bit m_wrap = 0;

  always #5 clk = ~clk;

  scan_decoder #(.IN_W(4), .DWELL_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy4), .addr(addr4), .dwell(dwell), .out_onehot(oh4),
    .out_valid(ov4), .cur_addr(cur4), .wrap(wrap4)
  );

  scan_decoder #(.IN_W(3), .DWELL_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy3), .addr(addr3), .dwell(dwell), .out_onehot(oh3),
    .out_valid(ov3), .cur_addr(cur3), .wrap(wrap3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected next-cycle behaviour from the mode rules, then one clock.
  task automatic step(input string tag);
    logic [15:0] exp_oh;
    #1;
    chk({tag, ".in_ready"}, 32'(rdy4), 32'(rst_n && en && !mode && (m_st == 1)));
    if (!rst_n || !en) begin
      m_st = 0; m_valid = 0; m_addr = 0; m_wrap = 0;
    end else if (!mode) begin
      m_wrap = 0;
      if (m_st != 1) begin
        m_st = 1; m_valid = 0; m_addr = 0;
      end else if (in_valid) begin
        m_valid = 1; m_addr = int'(addr4);
      end
    end else begin
      if (m_st != 2) begin
        m_st = 2; m_valid = 1; m_addr = 0; m_age = 0; m_dw = int'(dwell); m_wrap = 0;
      end else if (m_age == m_dw) begin
        m_wrap = (m_addr == 15);
        m_addr = (m_addr + 1) % 16;
        m_age = 0;
        m_dw = int'(dwell);
      end else begin
        m_age++;
        m_wrap = 0;
      end
    end
    @(posedge clk);
    #1;
    exp_oh = '0;
    if (m_valid) exp_oh[m_addr] = 1'b1;
    chk({tag, ".onehot"}, 32'(oh4), 32'(exp_oh));
    chk({tag, ".valid"}, 32'(ov4), 32'(m_valid));
    chk({tag, ".cur_addr"}, 32'(cur4), 32'(m_addr));
    chk({tag, ".wrap"}, 32'(wrap4), 32'(m_wrap));
  endtask

  initial begin
    int first_wrap;
    int n;
    bit found;
    logic [7:0] sb[$];
    logic [7:0] e3;

    // reset
    rst_n = 1'b0;
    step("reset");
    chk("reset.onehot_zero", 32'(oh4), 32'h0);

    // case 1: direct decode of address 5
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b1; addr4 = 4'd5;
    step("c1.entry");
    step("c1.hs");
    chk("c1.onehot_0x20", 32'(oh4), 32'h0020);
    chk("c1.in_ready", 32'(rdy4), 32'h1);
    in_valid = 1'b0; addr4 = 4'd9;
    repeat (3) step("c1.hold");

    // case 2: scan with dwell=2, first wrap at cycle 48
    mode = 1'b1; dwell = 8'd2;
    step("c2.entry");
    first_wrap = -1;
    n = 0;
    repeat (110) begin
      if (wrap4 && first_wrap < 0) first_wrap = n;
      step("c2.scan");
      n++;
    end
    chk("c2.first_wrap_cycle", 32'(first_wrap), 32'd48);

    // case 3: dwell=0 advances every cycle, direct inputs ignored
    dwell = 8'd0; in_valid = 1'b1;
    repeat (40) begin
      addr4 = 4'($urandom);
      step("c3.scan");
    end

    // case 4: drop en at index 7, then restart at 0
    dwell = 8'd1;
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (cur4 == 4'd7 && !wrap4) found = 1;
      else step("c4.seek");
    end
    chk("c4.reached_7", 32'(found), 32'd1);
    en = 1'b0;
    step("c4.en_off");
    chk("c4.off_zero", 32'(oh4), 32'h0);
    en = 1'b1;
    step("c4.restart");
    chk("c4.restart_idx", 32'(cur4), 32'h0);

    // case 5: one-cycle reset at index 9
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (cur4 == 4'd9) found = 1;
      else step("c5.seek");
    end
    chk("c5.reached_9", 32'(found), 32'd1);
    rst_n = 1'b0;
    step("c5.rst");
    rst_n = 1'b1;
    repeat (4) step("c5.resume");

    // random traffic including dwell changes mid-scan
    repeat (400) begin
      rst_n = ($urandom_range(0, 59) != 0);
      en = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      in_valid = 1'($urandom);
      addr4 = 4'($urandom);
      dwell = 8'($urandom_range(0, 3));
      step("rand");
    end

    // case 6: direct sweep on both widths with a scoreboard for the 3-bit one
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    step("c6.entry");
    for (int a = 0; a < 16; a++) begin
      addr4 = 4'(a);
      addr3 = 3'(a % 8);
      in_valid = 1'b1;
      if (rdy3) begin
        e3 = '0;
        e3[a % 8] = 1'b1;
        sb.push_back(e3);
      end
      step("c6.sweep");
      if (sb.size() > 0) chk("c6.w3_onehot", 32'(oh3), 32'(sb.pop_front()));
      else chk("c6.w3_ready", 32'(rdy3), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
